// File: rtl/vga_sync_monitor.sv
// VGA loopback monitor: recovers pixel coordinates, measures timing, tracks lock.
// Optional probe capture enabled by VGA_SYNC_MONITOR_PROBE_EN.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACT_START = 37,
  parameter int V_ACTIVE    = 478
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        VGA_CLK,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_cnt,
  output logic [23:0] probe_rgb,
  output logic        probe_valid
);

  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] HA0 = 10'(H_ACT_START);
  localparam logic [9:0] HA1 = 10'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [9:0] VA0 = 10'(V_ACT_START);
  localparam logic [9:0] VA1 = 10'(V_ACT_START + V_ACTIVE - 1);
  localparam logic [9:0] CMAX = 10'h3ff;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  good;
  logic [1:0]  good_nxt;
  logic        err;

  logic        vclk_q;
  logic        hs_q;
  logic        vs_q;
  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [9:0]  hcnt_nxt;
  logic [9:0]  vcnt_nxt;
  logic        pix_stb;
  logic        hs_fall;
  logic        vs_fall;
  logic [9:0]  h_meas;
  logic [9:0]  v_meas;
  logic        h_bad;
  logic        v_bad;
  logic        win;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [23:0] rgb;

  assign pix_stb = VGA_CLK & ~vclk_q;
  assign hs_fall = pix_stb & hs_q & ~VGA_HS;
  assign vs_fall = pix_stb & vs_q & ~VGA_VS;
  assign h_meas  = hcnt + 10'd1;
  assign v_meas  = vcnt + 10'd1;
  assign h_bad   = hs_fall && (h_meas != HT);
  assign v_bad   = vs_fall && (v_meas != VT);
  assign rgb     = {VGA_R, VGA_G, VGA_B};
  assign locked  = (state == LOCKED);

  always_comb begin
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    if (pix_stb) begin
      if (hs_fall) begin
        hcnt_nxt = '0;
        if (vcnt != CMAX) vcnt_nxt = vcnt + 10'd1;
      end else if (hcnt != CMAX) begin
        hcnt_nxt = hcnt + 10'd1;
      end
      if (vs_fall) vcnt_nxt = '0;
    end
  end

  // Window uses the post-update counts so the sample strobed now is tagged.
  assign px  = hcnt_nxt - HA0;
  assign py  = vcnt_nxt - VA0;
  assign win = pix_stb && locked &&
               (hcnt_nxt >= HA0) && (hcnt_nxt <= HA1) &&
               (vcnt_nxt >= VA0) && (vcnt_nxt <= VA1);

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    err       = 1'b0;
    unique case (state)
      SEARCH: begin
        good_nxt = '0;
        if (vs_fall) state_nxt = ACQUIRE;
      end
      ACQUIRE: begin
        if (h_bad || v_bad) begin
          state_nxt = SEARCH;
        end else if (vs_fall) begin
          if (good == 2'd1) state_nxt = LOCKED;
          else good_nxt = good + 2'd1;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad) begin
          err       = 1'b1;
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state     <= SEARCH;
      good      <= '0;
      vclk_q    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      h_total   <= '0;
      v_total   <= '0;
      frame_cnt <= '0;
      err_count <= '0;
      sync_err  <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_rgb   <= '0;
    end else begin
      state     <= state_nxt;
      good      <= good_nxt;
      vclk_q    <= VGA_CLK;
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      sync_err  <= err;
      pix_valid <= win;
      if (pix_stb) begin
        hs_q <= VGA_HS;
        vs_q <= VGA_VS;
      end
      if (hs_fall) h_total <= h_meas;
      if (vs_fall) begin
        v_total   <= v_meas;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err && (err_count != 8'hff))
        err_count <= err_count + 8'd1;
      if (win) begin
        pix_x   <= px;
        pix_y   <= py;
        pix_rgb <= rgb;
      end
    end
  end

`ifdef VGA_SYNC_MONITOR_PROBE_EN
  logic probe_hit;
  logic search_entry;

  assign probe_hit    = win && (px == probe_x) && (py == probe_y);
  assign search_entry = (state != SEARCH) && (state_nxt == SEARCH);

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else if (probe_hit) begin
      probe_rgb   <= rgb;
      probe_valid <= 1'b1;
    end else if (search_entry) begin
      probe_valid <= 1'b0;
    end
  end
`else
  logic unused_probe;

  assign unused_probe = ^{probe_x, probe_y};
  assign probe_rgb    = '0;
  assign probe_valid  = 1'b0;
`endif

endmodule
